// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: micro-ops, the execute bundle,
// FSM states and load-classification helpers.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU,
    OP_FLWS,
    OP_SB,
    OP_SH,
    OP_SW,
    OP_FSWS
  } op_t;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } mem_state_e;

  function automatic logic is_signed_load(op_t op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic is_fp_load(op_t op);
    return op == OP_FLWS;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data extraction: picks the byte/half addressed by off
// and sign- or zero-extends it to a full word.
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  op_t         op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;
  logic        is_b;
  logic        is_h;

  always_comb begin
    unique case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  assign sgn      = is_signed_load(op);
  assign is_b     = (op == OP_LB) || (op == OP_LBU);
  assign is_h     = (op == OP_LH) || (op == OP_LHU);

  always_comb begin
    data = rdata;
    unique case (1'b1)
      is_b:    data = {{24{sgn & byte_sel[7]}}, byte_sel};
      is_h:    data = {{16{sgn & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Blocking memory stage: one word-aligned data-bus access at a time,
// load extraction and GPR/FPR writeback, with flush-kill and timeout.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  op_t         op,
  input  mem_req_t    mem_req,
  output logic        mem_busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        wb_valid,
  output logic [31:0] gpr_wdata,
  output logic [31:0] fpr_wdata,
  output logic        load_fault,
  output logic        store_fault
);

  mem_state_e  state;
  op_t         op_q;
  logic [1:0]  off_q;
  logic        kill_q;
  logic        err_q;
  logic [15:0] tmo_cnt;

  logic        accept;
  logic        resp_hit;
  logic        tmo_hit;
  logic        to_done;
  logic        fp_ld;
  logic [31:0] rsp_data;
  logic [31:0] ext_data;

  assign accept = (state == IDLE) & in_valid
                & (mem_req.load | mem_req.store) & ~flush;

  assign mem_busy = accept | (state == REQ) | (state == RESP);
  assign bus_req  = (state == REQ);

  assign tmo_hit  = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign resp_hit = ((state == REQ) & bus_gnt & bus_rvalid)
                  | ((state == RESP) & bus_rvalid);
  assign to_done  = resp_hit | ((state == RESP) & tmo_hit);

  // A timed-out access has no read data; extract from zero.
  assign rsp_data = resp_hit ? bus_rdata : 32'h0;
  assign fp_ld    = is_fp_load(op_q);

  mem_access_stage_load_align u_load_align (
    .rdata (rsp_data),
    .off   (off_q),
    .op    (op_q),
    .data  (ext_data)
  );

  assign wb_valid    = (state == DONE) & ~kill_q & ~flush;
  assign load_fault  = wb_valid & err_q & ~bus_we;
  assign store_fault = wb_valid & err_q & bus_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      off_q     <= 2'b00;
      kill_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt   <= 16'h0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      gpr_wdata <= 32'h0;
      fpr_wdata <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          kill_q  <= 1'b0;
          tmo_cnt <= 16'h0;
          if (accept) begin
            op_q      <= op;
            off_q     <= mem_req.addr[1:0];
            bus_we    <= mem_req.store;
            bus_addr  <= {mem_req.addr[31:2], 2'b00};
            bus_be    <= mem_req.mask;
            bus_wdata <= mem_req.wdata;
            err_q     <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (flush) kill_q <= 1'b1;
          if (bus_gnt) state <= bus_rvalid ? DONE : RESP;
        end
        RESP: begin
          if (flush) kill_q <= 1'b1;
          if (to_done) begin
            tmo_cnt <= 16'h0;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
        end
        DONE: begin
          kill_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (to_done) begin
        err_q     <= resp_hit ? bus_err : 1'b1;
        gpr_wdata <= (bus_we | fp_ld) ? 32'h0 : ext_data;
        fpr_wdata <= (~bus_we & fp_ld) ? rsp_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: scheduled bus responses,
// a word-level load model and a per-cycle compare process.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int T = 8;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  op_t         op;
  mem_req_t    mem_req;
  logic        mem_busy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        wb_valid;
  logic [31:0] gpr_wdata;
  logic [31:0] fpr_wdata;
  logic        load_fault;
  logic        store_fault;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .op          (op),
    .mem_req     (mem_req),
    .mem_busy    (mem_busy),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err),
    .wb_valid    (wb_valid),
    .gpr_wdata   (gpr_wdata),
    .fpr_wdata   (fpr_wdata),
    .load_fault  (load_fault),
    .store_fault (store_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        chk_data = 1'b0;
  logic        chk_lit = 1'b0;
  logic        chk_zero = 1'b0;
  logic        e_busy, e_req, e_we, e_wb, e_lf, e_sf;
  logic [31:0] e_addr, e_wdata, e_gpr, e_fpr, l_gpr, l_fpr;
  logic [3:0]  e_be;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_busy", 32'(mem_busy), 32'(e_busy));
      chk("bus_req", 32'(bus_req), 32'(e_req));
      chk("wb_valid", 32'(wb_valid), 32'(e_wb));
      chk("load_fault", 32'(load_fault), 32'(e_lf));
      chk("store_fault", 32'(store_fault), 32'(e_sf));
      if (e_req) begin
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", 32'(bus_be), 32'(e_be));
        chk("bus_wdata", bus_wdata, e_wdata);
      end
      if (chk_zero) begin
        chk("rst_we", 32'(bus_we), 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_be", 32'(bus_be), 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
      end
      if (chk_data) begin
        chk("gpr_model", gpr_wdata, e_gpr);
        chk("fpr_model", fpr_wdata, e_fpr);
      end
      if (chk_lit) begin
        chk("gpr_lit", gpr_wdata, l_gpr);
        chk("fpr_lit", fpr_wdata, l_fpr);
      end
    end
  end

  // Writeback word as an ISA-level load would produce it: {gpr, fpr}.
  function automatic logic [63:0] model(op_t o, logic [1:0] off,
                                        logic [31:0] rd, logic st);
    logic [31:0] g;
    logic [31:0] f;
    logic [31:0] b;
    logic [31:0] h;
    g = 32'h0;
    f = 32'h0;
    b = (rd >> (32'(off) * 8)) & 32'hFF;
    h = (rd >> (32'(off[1]) * 16)) & 32'hFFFF;
    if (!st) begin
      case (o)
        OP_LB:   g = (b >= 32'h80) ? b - 32'h100 : b;
        OP_LBU:  g = b;
        OP_LH:   g = (h >= 32'h8000) ? h - 32'h10000 : h;
        OP_LHU:  g = h;
        OP_LW:   g = rd;
        OP_FLWS: f = rd;
        default: g = rd;
      endcase
    end
    return {g, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_busy = 1'b0; e_req = 1'b0; e_wb = 1'b0;
    e_lf = 1'b0; e_sf = 1'b0;
  endtask

  task automatic txn(op_t o, logic ld, logic st, logic [31:0] a,
                     logic [3:0] m, logic [31:0] wd, int gd, int rd,
                     logic [31:0] rdat, logic er, logic to, int fl,
                     logic use_lit, logic [31:0] lg, logic [31:0] lf);
    logic [63:0] md;
    logic kill;
    int n_resp;
    int c;
    md = model(o, a[1:0], rdat, st);
    kill = 1'b0;
    c = 0;
    idle_exp();
    chk_data = 1'b0; chk_lit = 1'b0;
    flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    in_valid = 1'b1; op = o;
    mem_req = '0;
    mem_req.load = ld; mem_req.store = st; mem_req.addr = a;
    mem_req.mask = m; mem_req.wdata = wd;
    e_busy = 1'b1;
    e_we = st; e_addr = {a[31:2], 2'b00}; e_be = m; e_wdata = wd;
    step(); c++;
    in_valid = 1'b0; mem_req = '0; op = OP_NOP;
    for (int k = 0; k <= gd; k++) begin
      flush = (c == fl); kill |= flush;
      bus_gnt = (k == gd);
      bus_rvalid = (k == gd) && (rd == 0) && !to;
      bus_rdata = rdat; bus_err = er;
      e_req = 1'b1; e_busy = 1'b1;
      step(); c++;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    n_resp = to ? T : rd;
    for (int j = 1; j <= n_resp; j++) begin
      flush = (c == fl); kill |= flush;
      bus_rvalid = !to && (j == rd);
      e_req = 1'b0; e_busy = 1'b1;
      step(); c++;
    end
    bus_rvalid = 1'b0; bus_err = 1'b0;
    flush = (c == fl); kill |= flush;
    e_req = 1'b0; e_busy = 1'b0;
    e_wb = !kill;
    e_lf = !kill && (er || to) && !st;
    e_sf = !kill && (er || to) && st;
    chk_data = !kill && !(er || to);
    e_gpr = md[63:32]; e_fpr = md[31:0];
    chk_lit = chk_data && use_lit; l_gpr = lg; l_fpr = lf;
    step();
    flush = 1'b0; idle_exp(); chk_lit = 1'b0;
    step();
    chk_data = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = OP_NOP;
    mem_req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_rdata = 32'h0; bus_err = 1'b0;
    idle_exp();
    e_we = 1'b0; e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
    e_gpr = 32'h0; e_fpr = 32'h0; l_gpr = 32'h0; l_fpr = 32'h0;
    step(); step();
    rst = 1'b0; chk_en = 1'b1; chk_zero = 1'b1; chk_data = 1'b1;
    step();
    chk_zero = 1'b0; chk_data = 1'b0;

    txn(OP_LB, Y, N, 32'h1003, 4'b1000, 32'h0, 0, 0,
        32'h80112233, N, N, -1, Y, 32'hFFFFFF80, 32'h0);
    txn(OP_LHU, Y, N, 32'h2002, 4'b1100, 32'h0, 3, 2,
        32'hBEEF1234, N, N, -1, Y, 32'h0000BEEF, 32'h0);
    txn(OP_SB, N, Y, 32'h3001, 4'b0010, 32'h0000AB00, 1, 1,
        32'h0, N, N, -1, Y, 32'h0, 32'h0);
    txn(OP_FLWS, Y, N, 32'h4000, 4'hF, 32'h0, 0, 1,
        32'h3F800000, Y, N, -1, N, 32'h0, 32'h0);
    txn(OP_SW, N, Y, 32'h4404, 4'hF, 32'h12345678, 0, 0,
        32'h0, N, Y, -1, N, 32'h0, 32'h0);
    txn(OP_LW, Y, N, 32'h5004, 4'hF, 32'h0, 1, 3,
        32'hCAFEF00D, N, N, 3, N, 32'h0, 32'h0);
    txn(OP_LH, Y, N, 32'h6002, 4'b1100, 32'h0, 0, 1,
        32'h80017FFF, N, N, -1, Y, 32'hFFFF8001, 32'h0);
    txn(OP_LBU, Y, N, 32'h7001, 4'b0010, 32'h0, 0, 0,
        32'h1234A5F0, N, N, -1, Y, 32'h000000A5, 32'h0);
    txn(OP_SW, N, Y, 32'h7100, 4'hF, 32'hA5A5A5A5, 2, 1,
        32'h0, N, N, 1, N, 32'h0, 32'h0);
    txn(OP_LW, Y, Y, 32'h7200, 4'hF, 32'h55AA55AA, 0, 0,
        32'hFFFFFFFF, N, N, -1, Y, 32'h0, 32'h0);
    txn(OP_LW, Y, N, 32'h7300, 4'hF, 32'h0, 0, 0,
        32'h11111111, N, N, 2, N, 32'h0, 32'h0);
    txn(OP_FLWS, Y, N, 32'h7400, 4'hF, 32'h0, 0, 1,
        32'h3F800000, N, N, -1, Y, 32'h0, 32'h3F800000);
    txn(OP_LW, Y, N, 32'h8000, 4'hF, 32'h0, 0, 1,
        32'hDEADBEEF, N, N, -1, Y, 32'hDEADBEEF, 32'h0);

    // Reset while waiting for a response, then a stray rvalid.
    in_valid = 1'b1; op = OP_LW; mem_req = '0;
    mem_req.load = 1'b1; mem_req.addr = 32'h9000; mem_req.mask = 4'hF;
    idle_exp(); e_busy = 1'b1;
    step();
    in_valid = 1'b0; mem_req = '0; op = OP_NOP; bus_gnt = 1'b1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h9000;
    e_be = 4'hF; e_wdata = 32'h0;
    step();
    bus_gnt = 1'b0; e_req = 1'b0; e_busy = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; idle_exp();
    chk_zero = 1'b1; chk_data = 1'b1; e_gpr = 32'h0; e_fpr = 32'h0;
    bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
    step();
    chk_zero = 1'b0;
    step();
    bus_rvalid = 1'b0;
    step();
    chk_data = 1'b0;

    txn(OP_LHU, Y, N, 32'hA000, 4'b0011, 32'h0, 1, 1,
        32'h0000F00D, N, N, -1, Y, 32'h0000F00D, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
